// File: rtl/boot_loader_pkg.sv
// Shared types and defaults for the SPI boot loader: FSM state encoding,
// memory base addresses and the largest image length accepted.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    BOOT_IDLE  = 3'd0,
    BOOT_LOAD  = 3'd1,
    BOOT_DRAIN = 3'd2,
    BOOT_DONE  = 3'd3,
    BOOT_RUN   = 3'd4,
    BOOT_ERR   = 3'd5
  } boot_state_e;

  localparam logic [31:0] ICCM_BASE_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] DCCM_BASE_DEFAULT = 32'h1000_0000;
  localparam int unsigned MAX_WORDS_DEFAULT = 4096;

endpackage

// File: rtl/boot_word_fifo.sv
// Synchronous word FIFO with registered occupancy count, flush, and a push
// that is accepted while full as long as a pop happens in the same cycle.
module boot_word_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/spi_boot_loader_ctrl.sv
// Boot loader sequencer: length-prefixed SPI word stream -> buffered memory
// writes into ICCM/DCCM, holding the core in reset until the image is loaded.
module spi_boot_loader_ctrl
  import boot_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_WORDS  = MAX_WORDS_DEFAULT,
  parameter logic [ADDR_WIDTH-1:0] ICCM_BASE = ADDR_WIDTH'(ICCM_BASE_DEFAULT),
  parameter logic [ADDR_WIDTH-1:0] DCCM_BASE = ADDR_WIDTH'(DCCM_BASE_DEFAULT)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  sel_i,
  input  logic [DATA_WIDTH-1:0] rx_word_i,
  input  logic                  rx_valid_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  output logic                  core_rst_no,
  output logic                  load_done_o,
  output logic                  err_o,
  output logic [15:0]           words_loaded_o
);

  localparam int unsigned CW = $clog2(MAX_WORDS + 1);

  localparam logic [2:0] S_IDLE  = BOOT_IDLE;
  localparam logic [2:0] S_LOAD  = BOOT_LOAD;
  localparam logic [2:0] S_DRAIN = BOOT_DRAIN;
  localparam logic [2:0] S_DONE  = BOOT_DONE;
  localparam logic [2:0] S_RUN   = BOOT_RUN;
  localparam logic [2:0] S_ERR   = BOOT_ERR;

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         hdr_q, hdr_d, rcv_q, rcv_d, iss_q, iss_d, gcnt_q, gcnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  req_q, req_d, done_q, done_d, err_q, err_d, rstn_q, rstn_d;
  logic [15:0]           wl_q, wl_d;

  logic                  grant, in_load, push_acc, can_load, overflow, last_grant, load_req;
  logic                  fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty, bypass;
  logic [DATA_WIDTH-1:0] fifo_rdata;

  assign grant      = req_q & mem_gnt_i;
  assign in_load    = (state_q == S_LOAD);
  assign push_acc   = in_load & rx_valid_i & (rcv_q < hdr_q);
  // The request register refills whenever it is free or being granted this cycle.
  assign can_load   = in_load & (~req_q | mem_gnt_i);
  assign fifo_pop   = can_load & ~fifo_empty;
  assign bypass     = can_load & fifo_empty & push_acc;
  assign overflow   = push_acc & fifo_full & ~fifo_pop;
  assign fifo_push  = push_acc & ~bypass & ~overflow;
  assign fifo_flush = (state_q == S_DRAIN) & (~req_q | mem_gnt_i);
  assign load_req   = fifo_pop | bypass;
  assign last_grant = grant & (gcnt_q == hdr_q - CW'(1));

  boot_word_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (rx_word_i),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    rcv_d   = rcv_q;
    iss_d   = iss_q;
    gcnt_d  = gcnt_q;
    base_d  = base_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    wl_d    = wl_q;

    if (load_req) begin
      req_d   = 1'b1;
      addr_d  = base_q + (ADDR_WIDTH'(iss_q) << 2);
      wdata_d = fifo_pop ? fifo_rdata : rx_word_i;
      iss_d   = iss_q + CW'(1);
    end else if (grant) begin
      req_d = 1'b0;
    end

    if (push_acc && !overflow) rcv_d = rcv_q + CW'(1);
    if (grant) begin
      gcnt_d = gcnt_q + CW'(1);
      if (wl_q != 16'hFFFF) wl_d = wl_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid_i) begin
          hdr_d  = CW'(rx_word_i);
          base_d = sel_i ? DCCM_BASE : ICCM_BASE;
          if (rx_word_i == '0) begin
            state_d = S_DONE;
          end else if (rx_word_i > DATA_WIDTH'(MAX_WORDS)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (overflow) begin
          state_d = S_DRAIN;
          err_d   = 1'b1;
        end else if (last_grant) begin
          state_d = S_DONE;
        end
      end
      S_DRAIN: if (fifo_flush) state_d = S_ERR;
      S_DONE:  if (en_i) state_d = S_RUN;
      default: state_d = state_q;
    endcase

    done_d = (state_d == S_DONE) || (state_d == S_RUN);
    rstn_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      hdr_q   <= '0;
      rcv_q   <= '0;
      iss_q   <= '0;
      gcnt_q  <= '0;
      base_q  <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rstn_q  <= 1'b0;
      wl_q    <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      rcv_q   <= rcv_d;
      iss_q   <= iss_d;
      gcnt_q  <= gcnt_d;
      base_q  <= base_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rstn_q  <= rstn_d;
      wl_q    <= wl_d;
    end
  end

  assign mem_req_o      = req_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign core_rst_no    = rstn_q;
  assign load_done_o    = done_q;
  assign err_o          = err_q;
  assign words_loaded_o = wl_q;

endmodule

// File: tb/tb_spi_boot_loader_ctrl.sv
// Directed bench for spi_boot_loader_ctrl: hand-computed vectors checked one
// cycle after each clock edge, plus a log of granted writes.
module tb_spi_boot_loader_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni, en_i, sel_i, rx_valid_i, mem_gnt_i;
  logic [31:0] rx_word_i;
  logic        mem_req_o, core_rst_no, load_done_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [15:0] words_loaded_o;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  spi_boot_loader_ctrl #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .FIFO_DEPTH (4),
    .MAX_WORDS  (4096),
    .ICCM_BASE  (32'h0000_0000),
    .DCCM_BASE  (32'h1000_0000)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .en_i           (en_i),
    .sel_i          (sel_i),
    .rx_word_i      (rx_word_i),
    .rx_valid_i     (rx_valid_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .core_rst_no    (core_rst_no),
    .load_done_o    (load_done_o),
    .err_o          (err_o),
    .words_loaded_o (words_loaded_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change 1ns after the rising edge, so mid-cycle shows what the next edge samples.
  always @(negedge clk_i) begin
    if (rst_ni && mem_req_o && mem_gnt_i) begin
      log_addr.push_back(mem_addr_o);
      log_data.push_back(mem_wdata_o);
    end
  end

  task automatic chk_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [31:0] w);
    rx_valid_i = 1'b1;
    rx_word_i  = w;
    step();
    rx_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rx_valid_i = 1'b0;
    rst_ni     = 1'b0;
    #2;
    rst_ni     = 1'b1;
    log_addr.delete();
    log_data.delete();
    step();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk_vec({tag, "_req"},  32'(mem_req_o),      32'd0);
    chk_vec({tag, "_addr"}, mem_addr_o,          32'd0);
    chk_vec({tag, "_data"}, mem_wdata_o,         32'd0);
    chk_vec({tag, "_crst"}, 32'(core_rst_no),    32'd0);
    chk_vec({tag, "_done"}, 32'(load_done_o),    32'd0);
    chk_vec({tag, "_err"},  32'(err_o),          32'd0);
    chk_vec({tag, "_wl"},   32'(words_loaded_o), 32'd0);
  endtask

  initial begin
    rst_ni = 1'b0; en_i = 1'b0; sel_i = 1'b0; rx_valid_i = 1'b0;
    rx_word_i = '0; mem_gnt_i = 1'b0;
    #1;
    chk_idle_outputs("rst");
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    step();

    // Header 3 into ICCM with grant always high.
    mem_gnt_i = 1'b1;
    drive(32'd3);
    chk_vec("t1_req_hdr", 32'(mem_req_o), 32'd0);
    drive(32'hA);
    chk_vec("t1_req0",  32'(mem_req_o), 32'd1);
    chk_vec("t1_addr0", mem_addr_o, 32'h0);
    chk_vec("t1_data0", mem_wdata_o, 32'hA);
    drive(32'hB);
    chk_vec("t1_addr1", mem_addr_o, 32'h4);
    chk_vec("t1_wl1",   32'(words_loaded_o), 32'd1);
    drive(32'hC);
    chk_vec("t1_addr2", mem_addr_o, 32'h8);
    chk_vec("t1_done_early", 32'(load_done_o), 32'd0);
    step();
    chk_vec("t1_done", 32'(load_done_o), 32'd1);
    chk_vec("t1_req_off", 32'(mem_req_o), 32'd0);
    chk_vec("t1_wl3", 32'(words_loaded_o), 32'd3);
    chk_vec("t1_crst_hold", 32'(core_rst_no), 32'd0);
    en_i = 1'b1;
    step();
    chk_vec("t1_crst_run", 32'(core_rst_no), 32'd1);
    chk_vec("t1_nwr", 32'(log_addr.size()), 32'd3);
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
      chk_vec("t1_log_addr", log_addr[i], 32'(4 * i));
      chk_vec("t1_log_data", log_data[i], 32'hA + 32'(i));
    end

    // Header 2 into DCCM, first word stalled for 5 cycles.
    en_i = 1'b0; mem_gnt_i = 1'b0;
    do_reset();
    sel_i = 1'b1;
    drive(32'd2);
    sel_i = 1'b0;
    drive(32'h11);
    chk_vec("t2_req", 32'(mem_req_o), 32'd1);
    chk_vec("t2_addr0", mem_addr_o, 32'h1000_0000);
    drive(32'h22);
    for (int i = 0; i < 4; i++) step();
    chk_vec("t2_stall_req",  32'(mem_req_o), 32'd1);
    chk_vec("t2_stall_addr", mem_addr_o, 32'h1000_0000);
    chk_vec("t2_stall_data", mem_wdata_o, 32'h11);
    mem_gnt_i = 1'b1;
    step();
    chk_vec("t2_addr1", mem_addr_o, 32'h1000_0004);
    chk_vec("t2_data1", mem_wdata_o, 32'h22);
    step();
    mem_gnt_i = 1'b0;
    chk_vec("t2_done", 32'(load_done_o), 32'd1);
    chk_vec("t2_wl", 32'(words_loaded_o), 32'd2);
    chk_vec("t2_nwr", 32'(log_addr.size()), 32'd2);

    // Header 0 and an oversize header.
    do_reset();
    drive(32'd0);
    chk_vec("t3_zero_done", 32'(load_done_o), 32'd1);
    chk_vec("t3_zero_req",  32'(mem_req_o), 32'd0);
    do_reset();
    drive(32'd5000);
    chk_vec("t3_big_err", 32'(err_o), 32'd1);
    en_i = 1'b1;
    step(); step();
    chk_vec("t3_big_crst", 32'(core_rst_no), 32'd0);
    chk_vec("t3_big_req",  32'(mem_req_o), 32'd0);
    en_i = 1'b0;

    // Overflow: 6 words with grant held low.
    do_reset();
    drive(32'd6);
    for (int i = 1; i <= 5; i++) drive(32'hD000_0000 + 32'(i));
    chk_vec("t4_err_pre", 32'(err_o), 32'd0);
    drive(32'hD000_0006);
    chk_vec("t4_err", 32'(err_o), 32'd1);
    chk_vec("t4_held_data", mem_wdata_o, 32'hD000_0001);
    chk_vec("t4_held_req",  32'(mem_req_o), 32'd1);
    mem_gnt_i = 1'b1;
    step();
    chk_vec("t4_req_drop", 32'(mem_req_o), 32'd0);
    chk_vec("t4_wl", 32'(words_loaded_o), 32'd1);
    en_i = 1'b1;
    step(); step();
    chk_vec("t4_no_req", 32'(mem_req_o), 32'd0);
    chk_vec("t4_crst", 32'(core_rst_no), 32'd0);
    chk_vec("t4_done", 32'(load_done_o), 32'd0);
    chk_vec("t4_nwr", 32'(log_addr.size()), 32'd1);

    // Same stream, grant coincident with the 6th word; en_i high throughout.
    mem_gnt_i = 1'b0;
    do_reset();
    drive(32'd6);
    for (int i = 1; i <= 5; i++) drive(32'hD000_0000 + 32'(i));
    chk_vec("t5_crst_load", 32'(core_rst_no), 32'd0);
    mem_gnt_i = 1'b1;
    drive(32'hD000_0006);
    chk_vec("t5_no_err", 32'(err_o), 32'd0);
    chk_vec("t5_data2", mem_wdata_o, 32'hD000_0002);
    chk_vec("t5_addr2", mem_addr_o, 32'h4);
    for (int i = 0; i < 4; i++) step();
    chk_vec("t5_addr6", mem_addr_o, 32'h14);
    chk_vec("t5_data6", mem_wdata_o, 32'hD000_0006);
    step();
    chk_vec("t5_done", 32'(load_done_o), 32'd1);
    chk_vec("t5_crst_done", 32'(core_rst_no), 32'd0);
    step();
    chk_vec("t5_crst_run", 32'(core_rst_no), 32'd1);
    chk_vec("t5_err_end", 32'(err_o), 32'd0);
    chk_vec("t5_nwr", 32'(log_addr.size()), 32'd6);
    en_i = 1'b0;

    // Async reset after 2 of 4 words granted, then a fresh 1-word load.
    do_reset();
    drive(32'd4);
    drive(32'hE1);
    drive(32'hE2);
    drive(32'hE3);
    chk_vec("t6_wl2", 32'(words_loaded_o), 32'd2);
    rst_ni = 1'b0;
    #1;
    chk_idle_outputs("t6_arst");
    #1 rst_ni = 1'b1;
    log_addr.delete();
    log_data.delete();
    step();
    drive(32'd1);
    drive(32'h55);
    chk_vec("t6_addr", mem_addr_o, 32'h0);
    chk_vec("t6_data", mem_wdata_o, 32'h55);
    step();
    chk_vec("t6_done", 32'(load_done_o), 32'd1);
    chk_vec("t6_wl", 32'(words_loaded_o), 32'd1);
    chk_vec("t6_nwr", 32'(log_addr.size()), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/spi_boot_loader_ctrl.md
# spi_boot_loader_ctrl

Sequencer between the SPI word deserializer and the on-chip memory write port. It accepts a length-prefixed stream of 32-bit words shifted in over SPI, buffers them in a small FIFO, and issues one memory write per word into ICCM or DCCM. It holds the core in reset until the image is fully written and `en_i` is asserted. It sits in `opentitan_soc_top` ahead of the crossbar host port used for boot loading.

## Interface
Parameters:
- `DATA_WIDTH`, 32: SPI word and memory data width.
- `ADDR_WIDTH`, 32: memory address width.
- `FIFO_DEPTH`, 4: buffer depth in words; power of two, ≥2.
- `MAX_WORDS`, 4096: largest legal image length.
- `ICCM_BASE`, 32'h0000_0000: load base address when `sel_i`=0.
- `DCCM_BASE`, 32'h1000_0000: load base address when `sel_i`=1.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `en_i` in 1: core run enable (level).
- `sel_i` in 1: target select, 0=ICCM, 1=DCCM; sampled with the header.
- `rx_word_i` in DATA_WIDTH: deserialized SPI word.
- `rx_valid_i` in 1: one-cycle strobe, `rx_word_i` valid.
- `mem_req_o` out 1: write request.
- `mem_addr_o` out ADDR_WIDTH: byte address.
- `mem_wdata_o` out DATA_WIDTH: write data.
- `mem_gnt_i` in 1: request accepted this cycle.
- `core_rst_no` out 1: core reset, active-low.
- `load_done_o` out 1: image fully written.
- `err_o` out 1: sticky error.
- `words_loaded_o` out 16: count of granted writes.

## Operation
- States: IDLE, LOAD, DRAIN_ERR, DONE, RUN, ERR.
- IDLE: the first `rx_valid_i` word is header N and is not written. Latch `sel_i` to choose the base.
  - N=0 → DONE.
  - N>MAX_WORDS → ERR.
  - Otherwise → LOAD.
- LOAD: each `rx_valid_i` pushes `rx_word_i` into the FIFO.
  - The memory side presents the FIFO head as a request; it pops on `mem_req_o && mem_gnt_i`.
  - Address = base + 4·k, where k is the word index from 0, truncated to ADDR_WIDTH.
  - After the N-th grant → DONE.
  - Words beyond N are ignored.
- Overflow: `rx_valid_i` while the FIFO is full and there is no pop this cycle.
  - `err_o` sets; the word is dropped; state → DRAIN_ERR.
  - Push while full with a simultaneous pop is accepted, not overflow.
- DRAIN_ERR: the in-flight request is held until granted. The FIFO is then flushed, with no further requests → ERR.
- DONE: `load_done_o`=1; `core_rst_no`=0. While `en_i`=1 → RUN.
- RUN: `core_rst_no`=1; terminal until reset. All `rx_valid_i` are ignored.
- ERR: terminal; `core_rst_no`=0; no requests.
- `en_i` is ignored in every state except DONE. A level held from earlier takes effect on DONE entry + 1.

## Timing
- Reset values: `mem_req_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `core_rst_no`=0, `load_done_o`=0, `err_o`=0, `words_loaded_o`=0, state IDLE, FIFO empty.
- All outputs are registered.
- Push in cycle t → `mem_req_o` at t+1 if the FIFO was empty and no request was pending.
- Back-to-back grants sustain 1 word/cycle.
- Once `mem_req_o` is asserted, `mem_req_o`, `mem_addr_o` and `mem_wdata_o` stay stable until the grant cycle. The request is never withdrawn.
- Next request follows in the cycle after a grant when the FIFO is non-empty.
- `words_loaded_o` increments in the cycle after each grant and saturates at 16'hFFFF.
- N-th grant at t → `load_done_o`=1 at t+1.
- DONE with `en_i`=1 at t → `core_rst_no`=1 at t+1.
- Async reset mid-load: all outputs return to reset values immediately and the partial image is abandoned.

## Structure
- Shared package `boot_loader_pkg` holds:
  - the state enum `boot_state_e`;
  - `ICCM_BASE` / `DCCM_BASE` defaults;
  - `MAX_WORDS_DEFAULT`.
- One sub-module, `boot_word_fifo`: synchronous FIFO with registered count, full/empty, and push-while-full-with-pop support.
- Controller FSM, address counter and word counter live in the top.

## Test plan
- Header 3 then 0xA, 0xB, 0xC with `sel_i`=0 and `mem_gnt_i`=1 → writes 0xA@0x0, 0xB@0x4, 0xC@0x8. `load_done_o` is high the cycle after the 3rd grant. `en_i`=1 → `core_rst_no`=1 one cycle later.
- Header 2 with `sel_i`=1, grant stalled 5 cycles on the first word → addresses 0x1000_0000 and 0x1000_0004. Request, address and data are stable across the stall.
- Header 0 → DONE next cycle with no `mem_req_o`. Header 5000 → ERR, `err_o`=1, `core_rst_no` stays 0.
- With FIFO_DEPTH=4 and `mem_gnt_i`=0, 6 back-to-back words:
  - the first word becomes the request and 4 words are buffered;
  - the 6th word → `err_o`, then DRAIN_ERR → ERR after the held grant.
  - Repeat with a grant coincident with the 6th word → no error.
- `en_i` high throughout a load → `core_rst_no` stays 0 until one cycle after DONE entry.
- `rst_ni` pulsed after 2 of 4 words are granted → immediate reset values. A fresh header 1 then loads correctly from base.
